// File: rtl/fir_tx_pkg.sv
// Shared types and constants for the FIR sample transmitter.
package fir_tx_pkg;
  localparam int TX_DW    = 10;
  localparam int TX_NTAPS = 11;

  // x^4 + x^3 + 1: feedback taps are bits 3 and 2 of a left-shifting register
  localparam logic [3:0] LFSR_SEED = 4'b1001;
  localparam logic [3:0] LFSR_POLY = 4'b1100;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_GAP   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic [3:0] lfsr_step(input logic [3:0] s);
    return {s[2:0], ^(s & LFSR_POLY)};
  endfunction
endpackage

// File: rtl/fir_stream_tx_if.sv
// Sample-push, control and filter-input stream signals of fir_stream_tx.
interface fir_stream_tx_if
  import fir_tx_pkg::*;
#(
  parameter int DW = TX_DW
) ();
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          wr_last;
  logic          full;
  logic          ovf;
  logic          start;
  logic [3:0]    gap;
  logic [DW-1:0] din;
  logic          vin;
  logic          busy;
  logic          end_sim;

  modport master (
    output wr_en, wr_data, wr_last, start, gap,
    input  full, ovf, din, vin, busy, end_sim
  );

  modport slave (
    input  wr_en, wr_data, wr_last, start, gap,
    output full, ovf, din, vin, busy, end_sim
  );
endinterface

// File: rtl/fir_tx_fifo.sv
// Synchronous show-ahead FIFO; dout is the head entry, zero latency from pop to next head.
// Pushes while full are dropped, even when a pop happens in the same cycle.
module fir_tx_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/fir_stream_tx.sv
// Rate-controlled FIR sample source: FIFO -> din/vin with programmable gap, drain, then end_sim.
// First vin two edges after start; FIR_TX_LFSR_GAP_EN masks the gap with a 4-bit LFSR.
module fir_stream_tx
  import fir_tx_pkg::*;
#(
  parameter int DW        = TX_DW,
  parameter int DEPTH     = 16,
  parameter int NTAPS     = TX_NTAPS,
  parameter int DRAIN_CYC = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  fir_stream_tx_if.slave  bus,
  input  logic            coef_we,
  input  logic [3:0]      coef_addr,
  input  logic [DW-1:0]   coef_data,
  output logic [DW-1:0]   b0,
  output logic [DW-1:0]   b1,
  output logic [DW-1:0]   b2,
  output logic [DW-1:0]   b3,
  output logic [DW-1:0]   b4,
  output logic [DW-1:0]   b5,
  output logic [DW-1:0]   b6,
  output logic [DW-1:0]   b7,
  output logic [DW-1:0]   b8,
  output logic [DW-1:0]   b9,
  output logic [DW-1:0]   b10
);
  localparam int CW = (DRAIN_CYC > 16) ? $clog2(DRAIN_CYC) : 4;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          pop;
  logic [DW:0]   head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [3:0]    gap_eff;
  logic [DW-1:0] din_r;
  logic          vin_r;
  logic          ovf_r;
  logic          busy_r;
  logic          end_sim_r;
  logic [DW-1:0] coef [NTAPS];

  fir_tx_fifo #(.W(DW + 1), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.wr_en),
    .din   ({bus.wr_last, bus.wr_data}),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef FIR_TX_LFSR_GAP_EN
  logic [3:0] lfsr;

  always_ff @(posedge clk) begin
    if (!rst_n)               lfsr <= LFSR_SEED;
    else if (state == ST_RUN) lfsr <= lfsr_step(lfsr);
  end

  assign gap_eff = bus.gap & lfsr;
`else
  assign gap_eff = bus.gap;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // cnt holds the remaining GAP cycles, or DRAIN cycles minus one
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start && !fifo_empty) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head[DW]) begin
            state_next = ST_DRAIN;
            cnt_next   = CW'(DRAIN_CYC - 1);
          end else if (gap_eff != 4'd0) begin
            state_next = ST_GAP;
            cnt_next   = CW'(gap_eff);
          end
        end
      end
      ST_GAP: begin
        if (cnt <= CW'(1)) state_next = ST_RUN;
        else               cnt_next   = cnt - 1'b1;
      end
      ST_DRAIN: begin
        if (cnt == '0) state_next = ST_DONE;
        else           cnt_next   = cnt - 1'b1;
      end
      ST_DONE: begin
        if (bus.start) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      din_r     <= '0;
      vin_r     <= 1'b0;
      ovf_r     <= 1'b0;
      busy_r    <= 1'b0;
      end_sim_r <= 1'b0;
    end else begin
      vin_r     <= pop;
      if (pop) din_r <= head[DW-1:0];
      ovf_r     <= ovf_r | (bus.wr_en & fifo_full);
      busy_r    <= (state_next != ST_IDLE);
      end_sim_r <= (state == ST_DONE) && !bus.start;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) coef[i] <= '0;
    end else if (coef_we && state == ST_IDLE && coef_addr < 4'(NTAPS)) begin
      coef[coef_addr] <= coef_data;
    end
  end

  assign bus.full    = fifo_full;
  assign bus.ovf     = ovf_r;
  assign bus.din     = din_r;
  assign bus.vin     = vin_r;
  assign bus.busy    = busy_r;
  assign bus.end_sim = end_sim_r;

  assign b0  = coef[0];
  assign b1  = coef[1];
  assign b2  = coef[2];
  assign b3  = coef[3];
  assign b4  = coef[4];
  assign b5  = coef[5];
  assign b6  = coef[6];
  assign b7  = coef[7];
  assign b8  = coef[8];
  assign b9  = coef[9];
  assign b10 = coef[10];
endmodule

// File: doc/fir_stream_tx.md
# fir_stream_tx

Synthesizable sample transmitter that drives the FIR filter input side (`din`/`vin`) and its coefficient ports `b0`..`b10`, mirroring the data sink at the output end. Samples are pushed into an internal FIFO, then streamed to the filter with a programmable idle gap between valid samples. After the last sample a drain interval runs, then `end_sim` is raised. The block replaces the behavioural signal generator with a rate-controllable source.

## Interface
- `DW`, 10, sample and coefficient width
- `DEPTH`, 16, FIFO depth in entries (power of two)
- `NTAPS`, 11, number of coefficient registers
- `DRAIN_CYC`, 16, cycles between the last `vin` and `end_sim`
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  reset; synchronous, active-low
- `wr_en`  in  1  push `wr_data`/`wr_last` into the FIFO
- `wr_data`  in  DW  sample to push
- `wr_last`  in  1  marks the final sample of the stream
- `full`  out  1  FIFO holds DEPTH entries
- `ovf`  out  1  sticky: a push was dropped
- `start`  in  1  begin streaming (IDLE) / acknowledge completion (DONE)
- `gap`  in  4  idle cycles inserted after each valid sample
- `coef_we`  in  1  coefficient write strobe
- `coef_addr`  in  4  coefficient index 0..10
- `coef_data`  in  DW  coefficient value
- `b0`..`b10`  out  DW each  coefficient registers to the filter
- `din`  out  DW  sample to the filter
- `vin`  out  1  `din` valid, one-cycle pulse per sample
- `busy`  out  1  state is not IDLE
- `end_sim`  out  1  stream completed and drained

## Operation
- States: IDLE, RUN, GAP, DRAIN, DONE.
- IDLE:
  - `start`=1 and FIFO non-empty -> RUN.
  - `start` with an empty FIFO is ignored.
- RUN:
  - FIFO non-empty: pop the head and register `din`=data, `vin`=1.
    - Popped entry has last=1 -> DRAIN.
    - Otherwise, `gap`>0 -> GAP.
    - Otherwise stay in RUN.
  - FIFO empty (underrun): `vin`=0, `din` holds its value, stay in RUN.
- GAP: `vin`=0 for exactly `gap` cycles, then return to RUN. `gap` is sampled when entering GAP.
- DRAIN: `vin`=0 for DRAIN_CYC cycles, then DONE.
- DONE: `end_sim`=1 and held. `start` -> IDLE and `end_sim` cleared.
- FIFO:
  - Entries are DW+1 bits (data plus last flag).
  - A push when `full`=1 is dropped and sets `ovf`, even if a pop happens in the same cycle.
  - Push and pop in the same cycle when not full: both occur.
  - Pointers wrap modulo DEPTH.
  - Pushes are accepted in every state.
- Coefficients:
  - `coef_we` writes `b[coef_addr]` in IDLE only.
  - Writes outside IDLE, or with `coef_addr` 11..15, are ignored.
- Reset values (`rst_n`=0 at an edge):
  - state IDLE.
  - FIFO emptied.
  - `din`=0, `vin`=0, `b0`..`b10`=0.
  - `full`=0, `ovf`=0, `busy`=0, `end_sim`=0.
  - LFSR seeded to 4'b1001.
  - Reset mid-stream discards all queued samples.

## Timing
- `start` sampled high at edge k -> first `vin`=1 after edge k+1.
- `gap`=0: one sample per cycle, back-to-back.
- `gap`=g: `vin` high for 1 cycle, then low for g cycles, i.e. period g+1.
- Last `vin` after edge m -> `end_sim`=1 after edge m+DRAIN_CYC+1.
- `full` and `busy` are registered and update on the edge following the causing event.
- `din`/`vin` are registered outputs; there are no combinational paths from inputs to outputs.

## Configuration
- `FIR_TX_LFSR_GAP_EN` defined:
  - The GAP length is `gap & lfsr[3:0]`, sampled on entry to GAP.
  - A 4-bit maximal LFSR (x^4+x^3+1) advances on every cycle spent in RUN.
  - If the masked value is 0, the next state is RUN directly.
- Undefined: the GAP length equals `gap` exactly; no LFSR is instantiated.

## Structure
- Package `fir_tx_pkg`:
  - state encoding (IDLE=0, RUN=1, GAP=2, DRAIN=3, DONE=4).
  - DW, NTAPS, LFSR seed, and the LFSR polynomial constant.
- Sub-module `fir_tx_fifo`:
  - Synchronous FIFO, DEPTH × (DW+1).
  - Ports: push, pop, data in/out, full, empty.
  - Drop-on-full behaviour.
- Top level holds the FSM, gap/drain counters, coefficient bank, and LFSR.

## Test plan
- Write coefficients 1..11 to addresses 0..10 in IDLE; write to address 12 -> `b0`..`b10` read 1..11, nothing else changes; `coef_we` while in RUN leaves them unchanged.
- Push 5 samples 10,20,30,40,50 (last on 50), `gap`=0, `start` -> `vin` high for 5 consecutive cycles with `din` 10..50; `end_sim` rises 17 cycles after the last `vin`.
- Same stream with `gap`=3 -> each `vin` pulse is followed by exactly 3 idle cycles; total span from first to last `vin` is 17 cycles.
- Push 17 samples while IDLE -> `full`=1 after the 16th; the 17th is dropped and `ovf`=1; the stream outputs 16 values.
- Push 2 samples (no last), `start`, then push the third with last 10 cycles later -> `vin` low during the underrun; the third sample is sent, then DRAIN and DONE; `start` in DONE clears `end_sim`.
- Assert `rst_n`=0 mid-stream for 1 cycle -> all outputs at reset values on the next cycle; FIFO empty; `start` is then ignored until a new push.
